// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: two-pass nibble sequencer for the SM83 8-bit ALU.
// Each 8-bit op runs as a LO pass (bits 3:0) and then a HI pass (bits 7:4), with the carry
// chained between the passes. The result and the raw flag strobes are registered on the edge
// that leaves HI, and done pulses for that one cycle.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     accept op/a/b/c_in/n_in/h_in when idle
//   op[4:0]                   operation select; codes 17..31 act as NOP
//   a, b                      operands
//   c_in, n_in, h_in          current C/N/H flags
//   busy                      high in the LO and HI states
//   done                      one-cycle pulse; the outputs below are valid
//   result                    op result
//   zero_out, half_carry_out, carry_out, sign_out, shift_out, daa_carry_out   raw flag strobes
module sm83_alu_seq #(
  parameter int unsigned WORD_SIZE = 8  // must be 8: the datapath is two nibble passes
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [4:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 c_in,
  input  logic                 n_in,
  input  logic                 h_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 zero_out,
  output logic                 half_carry_out,
  output logic                 carry_out,
  output logic                 sign_out,
  output logic                 shift_out,
  output logic                 daa_carry_out
);

  localparam logic [4:0] OpAdd = 5'd0,  OpAdc = 5'd1,  OpSub = 5'd2,  OpSbc = 5'd3;
  localparam logic [4:0] OpAnd = 5'd4,  OpXor = 5'd5,  OpOr  = 5'd6,  OpCp  = 5'd7;
  localparam logic [4:0] OpRlc = 5'd8,  OpRrc = 5'd9,  OpRl  = 5'd10, OpRr  = 5'd11;
  localparam logic [4:0] OpSla = 5'd12, OpSra = 5'd13, OpSrl = 5'd14, OpSwap = 5'd15;
  localparam logic [4:0] OpDaa = 5'd16;

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_t;

  state_t     state;
  logic [4:0] op_q;
  logic [7:0] a_q, b_q;
  logic       c_q, n_q;
  logic       lo_adj_q, hi_adj_q;
  logic [3:0] lo_res_q;
  logic       mid_carry_q;   // raw adder carry out of the LO pass
  logic       lo_zero_q;

  // Per-pass datapath, shared by both passes.
  logic       pass_hi, is_sub, is_arith, is_left, is_right, is_nop;
  logic [3:0] na, nb, adder_b, nib_res, zero_nib, daa_k;
  logic       cin_lo, cin, fill_left, fill_right, carry_raw;
  logic [4:0] sum5;

  always_comb begin
    pass_hi  = (state == StHi);
    na       = pass_hi ? a_q[7:4] : a_q[3:0];
    nb       = pass_hi ? b_q[7:4] : b_q[3:0];
    is_sub   = (op_q == OpSub) || (op_q == OpSbc) || (op_q == OpCp);
    is_arith = (op_q <= OpSbc) || (op_q == OpCp);
    is_left  = (op_q == OpRlc) || (op_q == OpRl) || (op_q == OpSla);
    is_right = (op_q == OpRrc) || (op_q == OpRr) || (op_q == OpSra) || (op_q == OpSrl);
    is_nop   = (op_q > OpDaa);

    // DAA adds or subtracts 6 per nibble; subtraction is a + ~k + 1 through the carry chain.
    daa_k = (pass_hi ? hi_adj_q : lo_adj_q) ? 4'd6 : 4'd0;

    cin_lo  = 1'b0;
    adder_b = nb;
    unique case (op_q)
      OpAdc:       cin_lo = c_q;
      OpSub, OpCp: begin cin_lo = 1'b1; adder_b = ~nb; end
      OpSbc:       begin cin_lo = ~c_q; adder_b = ~nb; end
      OpDaa:       begin cin_lo = n_q;  adder_b = n_q ? ~daa_k : daa_k; end
      default:     ;
    endcase
    cin       = pass_hi ? mid_carry_q : cin_lo;
    sum5      = {1'b0, na} + {1'b0, adder_b} + {4'b0000, cin};
    carry_raw = sum5[4];

    fill_left  = (op_q == OpRlc) ? a_q[7] : (op_q == OpRl) ? c_q : 1'b0;
    fill_right = (op_q == OpRrc) ? a_q[0] : (op_q == OpRr) ? c_q :
                 (op_q == OpSra) ? a_q[7] : 1'b0;

    if (is_arith && op_q != OpCp || op_q == OpDaa) begin
      nib_res = sum5[3:0];
    end else if (op_q == OpAnd) begin
      nib_res = na & nb;
    end else if (op_q == OpXor) begin
      nib_res = na ^ nb;
    end else if (op_q == OpOr) begin
      nib_res = na | nb;
    end else if (is_left) begin
      nib_res = pass_hi ? {a_q[6:4], a_q[3]} : {a_q[2:0], fill_left};
    end else if (is_right) begin
      nib_res = pass_hi ? {fill_right, a_q[7:5]} : {a_q[4], a_q[3:1]};
    end else if (op_q == OpSwap) begin
      nib_res = pass_hi ? a_q[3:0] : a_q[7:4];
    end else begin
      nib_res = na;  // CP and NOP pass a through
    end

    // CP reports zero on the difference, not on the passed-through operand.
    zero_nib = (op_q == OpCp) ? sum5[3:0] : nib_res;
  end

  assign busy = (state == StLo) || (state == StHi);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      op_q           <= 5'd0;
      a_q            <= 8'h00;
      b_q            <= 8'h00;
      c_q            <= 1'b0;
      n_q            <= 1'b0;
      lo_adj_q       <= 1'b0;
      hi_adj_q       <= 1'b0;
      lo_res_q       <= 4'h0;
      mid_carry_q    <= 1'b0;
      lo_zero_q      <= 1'b0;
      done           <= 1'b0;
      result         <= 8'h00;
      zero_out       <= 1'b0;
      half_carry_out <= 1'b0;
      carry_out      <= 1'b0;
      sign_out       <= 1'b0;
      shift_out      <= 1'b0;
      daa_carry_out  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state    <= StLo;
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            c_q      <= c_in;
            n_q      <= n_in;
            lo_adj_q <= h_in | (~n_in & (a[3:0] > 4'd9));
            hi_adj_q <= c_in | (~n_in & (a > 8'h99));
          end
        end
        StLo: begin
          state       <= StHi;
          lo_res_q    <= nib_res;
          mid_carry_q <= carry_raw;
          lo_zero_q   <= (zero_nib == 4'h0);
        end
        StHi: begin
          state          <= StIdle;
          done           <= 1'b1;
          result         <= (op_q == OpCp) ? a_q : {nib_res, lo_res_q};
          zero_out       <= ~is_nop & lo_zero_q & (zero_nib == 4'h0);
          // Sub ops turn carries into borrows.
          half_carry_out <= is_arith ? (mid_carry_q ^ is_sub) : (op_q == OpAnd);
          carry_out      <= is_arith & (carry_raw ^ is_sub);
          sign_out       <= is_sub;
          shift_out      <= (is_left & a_q[7]) | (is_right & a_q[0]);
          daa_carry_out  <= (op_q == OpDaa) & hi_adj_q;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Scoreboard bench for sm83_alu_seq: the driver pushes hand-computed expectations, and a
// monitor pops and compares them whenever done is high.
module tb_sm83_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] op = 5'd0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       c_in = 1'b0, n_in = 1'b0, h_in = 1'b0;
  logic       busy, done;
  logic [7:0] result;
  logic       zero_out, half_carry_out, carry_out, sign_out, shift_out, daa_carry_out;

  sm83_alu_seq #(.WORD_SIZE(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .c_in(c_in), .n_in(n_in), .h_in(h_in), .busy(busy), .done(done), .result(result),
    .zero_out(zero_out), .half_carry_out(half_carry_out), .carry_out(carry_out),
    .sign_out(sign_out), .shift_out(shift_out), .daa_carry_out(daa_carry_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic z, h, c, s, sh, d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("zero", zero_out, e.z);
        check("half", half_carry_out, e.h);
        check("carry", carry_out, e.c);
        check("sign", sign_out, e.s);
        check("shift", shift_out, e.sh);
        check("daa_carry", daa_carry_out, e.d);
      end
    end
  end

  // Called just after a negedge; returns at the negedge of the done cycle with start low,
  // so the next call issues back-to-back in the done cycle.
  task automatic run_op(input logic [4:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic c, input logic n, input logic h, input exp_t e,
                        input bit poke_busy);
    op = o; a = va; b = vb; c_in = c; n_in = n; h_in = h; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    // Inputs are don't-care after the accepting edge.
    a = 8'($urandom); b = 8'($urandom); op = 5'($urandom_range(0, 16));
    c_in = ~c; n_in = ~n; h_in = ~h;
    start = poke_busy;
    check("busy_lo", busy, 1);
    check("done_lo", done, 0);
    @(negedge clk);
    check("busy_hi", busy, 1);
    @(negedge clk);
    start = 1'b0;
    check("done_latency", done, 1);
    check("busy_done", busy, 0);
  endtask

  initial begin
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    //      op     a      b      c     n     h      res    z  h  c  s  sh d
    run_op(5'd0,  8'h3A, 8'hC6, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 1, 1, 0, 0, 0}, 0); // ADD
    run_op(5'd2,  8'h10, 8'h01, 1'b0, 1'b0, 1'b0, '{8'h0F, 0, 1, 0, 1, 0, 0}, 0); // SUB
    run_op(5'd7,  8'h3E, 8'h3E, 1'b0, 1'b0, 1'b0, '{8'h3E, 1, 0, 0, 1, 0, 0}, 0); // CP
    run_op(5'd16, 8'h7D, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h83, 0, 0, 0, 0, 0, 0}, 0); // DAA
    run_op(5'd16, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 0, 0, 0, 0, 1}, 0); // DAA
    run_op(5'd16, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, '{8'h09, 0, 0, 0, 0, 0, 0}, 0); // DAA n=1
    run_op(5'd8,  8'h85, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h0B, 0, 0, 0, 0, 1, 0}, 0); // RLC
    run_op(5'd13, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, '{8'hC0, 0, 0, 0, 0, 1, 0}, 0); // SRA
    run_op(5'd15, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h0F, 0, 0, 0, 0, 0, 0}, 0); // SWAP
    run_op(5'd1,  8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, '{8'h10, 0, 1, 0, 0, 0, 0}, 0); // ADC
    run_op(5'd3,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '{8'hFF, 0, 1, 1, 1, 0, 0}, 0); // SBC
    run_op(5'd4,  8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 1, 0, 0, 0, 0}, 0); // AND
    run_op(5'd5,  8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 0, 0, 0, 0, 0}, 0); // XOR
    run_op(5'd6,  8'h50, 8'h03, 1'b0, 1'b0, 1'b0, '{8'h53, 0, 0, 0, 0, 0, 0}, 0); // OR
    run_op(5'd11, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, '{8'h80, 0, 0, 0, 0, 1, 0}, 0); // RR
    run_op(5'd14, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 0, 0, 0, 1, 0}, 0); // SRL
    run_op(5'd12, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h00, 1, 0, 0, 0, 1, 0}, 0); // SLA
    run_op(5'd10, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, '{8'h01, 0, 0, 0, 0, 1, 0}, 0); // RL
    run_op(5'd9,  8'h01, 8'h00, 1'b0, 1'b0, 1'b0, '{8'h80, 0, 0, 0, 0, 1, 0}, 0); // RRC
    run_op(5'd20, 8'h77, 8'h12, 1'b1, 1'b1, 1'b1, '{8'h77, 0, 0, 0, 0, 0, 0}, 0); // NOP
    // start held in LO and HI must be ignored: one done, then idle.
    run_op(5'd0,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0, '{8'h02, 0, 0, 0, 0, 0, 0}, 1);
    repeat (4) begin
      @(negedge clk);
      check("idle_after_ignore", busy, 0);
    end

    // Abort during HI: everything clears at once and no done follows.
    op = 5'd0; a = 8'h22; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_in_hi", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_op(5'd0,  8'h12, 8'h34, 1'b0, 1'b0, 1'b0, '{8'h46, 0, 0, 0, 0, 0, 0}, 0);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
